// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake and serial output bundle for
// piso_serializer. The slave modport is the serializer's view; the master
// modport is the view of whatever drives words in and consumes bits.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             shift_en;
  logic             data_out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid,
    output load_data,
    output shift_en,
    input  load_ready,
    input  data_out,
    input  out_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  shift_en,
    output load_ready,
    output data_out,
    output out_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out shifter, MSB first.
// A word is taken through a valid/ready handshake while idle, then one bit
// leaves per cycle with shift_en high. done pulses for one cycle after the
// final bit has been shifted out.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN appends an even-parity
// bit after the LSB.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  piso_serializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt;
  logic             done_reg;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             parity_reg;
`endif

  // Ready only while idle, and never during a reset cycle.
  assign bus.load_ready = (state == IDLE) && !reset;

  // Serial outputs are decoded from registers only; data_out is forced low
  // whenever no valid bit is on the wire.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.data_out  = 1'b0;
    case (state)
      SHIFT: begin
        bus.out_valid = 1'b1;
        bus.data_out  = shift_reg[WIDTH-1];
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        bus.out_valid = 1'b1;
        bus.data_out  = parity_reg;
      end
`endif
      default: begin
        bus.out_valid = 1'b0;
        bus.data_out  = 1'b0;
      end
    endcase
  end

  assign bus.busy = bus.out_valid;
  assign bus.done = done_reg;

  // Control FSM and datapath: load on handshake, shift on each qualified
  // strobe, pulse done when the last bit of the word leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      done_reg  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            shift_reg <= bus.load_data;
            cnt       <= CW'(WIDTH);
            state     <= SHIFT;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_reg <= ^bus.load_data;
`endif
          end
        end
        SHIFT: begin
          if (bus.shift_en) begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            cnt       <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
`ifdef PISO_SERIALIZER_PARITY_EN
              state <= PARITY;
`else
              state    <= IDLE;
              done_reg <= 1'b1;
`endif
            end
          end
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        PARITY: begin
          if (bus.shift_en) begin
            state    <= IDLE;
            done_reg <= 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: randomized and directed checks of piso_serializer
// against a receiver-style model that rebuilds the word from captured bits.
module tb_piso_serializer;

  localparam int WIDTH = 4;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NEXP = WIDTH + PAR;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cycle_cnt = 0;
  int   done_total = 0;

  piso_serializer_if #(.WIDTH(WIDTH)) bus ();

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle_cnt = cycle_cnt + 1;
    #2;
    if (bus.done === 1'b1) done_total = done_total + 1;
  end

  // Expected serial stream: the word MSB first, then even parity if enabled.
  function automatic logic [63:0] expect_bits(input logic [WIDTH-1:0] w);
    logic [63:0] v;
    v = 64'(w);
    if (PAR == 1) v = (v << 1) | 64'($countones(w) % 2);
    return v;
  endfunction

  // Offers a word, drives shift_en per mode (0 continuous, 1 fixed stall
  // pattern, 2 random) and captures each bit on a qualified shift, exactly as
  // a paired receiver would. Returns at the negedge where done is seen.
  task automatic run_word(input logic [WIDTH-1:0] word, input int mode,
                          input bit midload, input logic [WIDTH-1:0] other,
                          output logic [63:0] obs, output int nbits,
                          output bit gap_ok, output int ready_busy,
                          output bit timeout, output int hs_cycle);
    int  pattern[7] = '{1, 0, 0, 1, 1, 0, 1};
    int  wait_c = 0;
    int  cyc = 0;
    int  last_shift = -10;
    bit  got = 0;
    bit  se;
    obs = 0; nbits = 0; gap_ok = 0; ready_busy = 0; timeout = 0;
    while (bus.load_ready !== 1'b1 && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    bus.load_valid = 1'b1;
    bus.load_data  = word;
    bus.shift_en   = 1'b0;
    hs_cycle = cycle_cnt;
    @(negedge clk);
    bus.load_valid = 1'b0;
    while (!got && cyc < 400) begin
      if (bus.done === 1'b1) begin
        got = 1;
        gap_ok = (last_shift == cyc - 1) && (bus.out_valid === 1'b0) &&
                 (bus.data_out === 1'b0) && (bus.load_ready === 1'b1);
      end else begin
        if (bus.out_valid === 1'b1 && bus.load_ready !== 1'b0) ready_busy++;
        case (mode)
          0: se = 1'b1;
          1: se = (pattern[cyc % 7] == 1);
          default: se = 1'($urandom_range(0, 1));
        endcase
        bus.shift_en   = se;
        bus.load_valid = midload && (bus.out_valid === 1'b1);
        bus.load_data  = midload ? other : word;
        if (bus.out_valid === 1'b1 && se) begin
          obs = (obs << 1) | 64'(bus.data_out);
          nbits++;
          last_shift = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.shift_en   = 1'b0;
    bus.load_valid = 1'b0;
    timeout = !got;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.shift_en   = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got %b want 0", bus.load_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.data_out !== 1'b0) begin errors++; $display("FAIL reset_data_out got %b want 0", bus.data_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", bus.load_ready); end
    $display("test_reset done");
  endtask

  task automatic test_word(input string name, input logic [WIDTH-1:0] w, input int mode);
    logic [63:0] obs; int nb; bit gap; int rb; bit to; int hs; int d0;
    d0 = done_total;
    run_word(w, mode, 1'b0, '0, obs, nb, gap, rb, to, hs);
    checks++; if (to) begin errors++; $display("FAIL %s_timeout got timeout want done", name); end
    checks++; if (nb != NEXP) begin errors++; $display("FAIL %s_nbits got %0d want %0d", name, nb, NEXP); end
    checks++; if (obs !== expect_bits(w)) begin errors++; $display("FAIL %s_bits got %h want %h", name, obs, expect_bits(w)); end
    checks++; if (!gap) begin errors++; $display("FAIL %s_done_timing got bad want done right after last shift", name); end
    checks++; if (rb != 0) begin errors++; $display("FAIL %s_ready_busy got %0d want 0", name, rb); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_width got %b want 0", name, bus.done); end
    checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL %s_done_count got %0d want 1", name, done_total - d0); end
    $display("%s word=%h bits=%h nbits=%0d", name, w, obs, nb);
  endtask

  task automatic test_continuous();
    test_word("continuous", WIDTH'(4'b1011), 0);
  endtask

  task automatic test_stall();
    test_word("stall", WIDTH'(4'b1011), 1);
  endtask

  task automatic test_midword_load();
    logic [63:0] obs; int nb; bit gap; int rb; bit to; int hs; int d0;
    d0 = done_total;
    run_word(WIDTH'(4'b1011), 0, 1'b1, WIDTH'(4'b0110), obs, nb, gap, rb, to, hs);
    checks++; if (obs !== expect_bits(WIDTH'(4'b1011))) begin errors++; $display("FAIL midload_bits got %h want %h", obs, expect_bits(WIDTH'(4'b1011))); end
    checks++; if (rb != 0) begin errors++; $display("FAIL midload_ready_busy got %0d want 0", rb); end
    checks++; if (to || !gap) begin errors++; $display("FAIL midload_done got to=%b gap=%b want 0/1", to, gap); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midload_ignored got out_valid %b want 0", bus.out_valid); end
    end
    checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL midload_done_count got %0d want 1", done_total - d0); end
    $display("midload bits=%h", obs);
  endtask

  task automatic test_reset_abort();
    int d0;
    d0 = done_total;
    bus.load_valid = 1'b1;
    bus.load_data  = WIDTH'(4'b1100);
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.shift_en   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.data_out !== 1'b0) begin errors++; $display("FAIL abort_data_out got %b want 0", bus.data_out); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", bus.load_ready); end
    reset = 1'b0;
    bus.shift_en = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (done_total != d0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_total - d0); end
    $display("reset_abort done");
    test_word("after_abort", WIDTH'(4'b0101), 0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] obs1, obs2; int nb1, nb2; bit g1, g2; int rb1, rb2; bit to1, to2; int hs1, hs2;
    run_word(WIDTH'(4'b1001), 0, 1'b0, '0, obs1, nb1, g1, rb1, to1, hs1);
    run_word(WIDTH'(4'b0110), 0, 1'b0, '0, obs2, nb2, g2, rb2, to2, hs2);
    checks++; if (obs1 !== expect_bits(WIDTH'(4'b1001))) begin errors++; $display("FAIL b2b_word1 got %h want %h", obs1, expect_bits(WIDTH'(4'b1001))); end
    checks++; if (obs2 !== expect_bits(WIDTH'(4'b0110))) begin errors++; $display("FAIL b2b_word2 got %h want %h", obs2, expect_bits(WIDTH'(4'b0110))); end
    checks++; if (hs2 - hs1 != WIDTH + 1 + PAR) begin errors++; $display("FAIL b2b_period got %0d want %0d", hs2 - hs1, WIDTH + 1 + PAR); end
    checks++; if (to1 || to2 || !g1 || !g2) begin errors++; $display("FAIL b2b_done got to=%b%b gap=%b%b want 00/11", to1, to2, g1, g2); end
    $display("back_to_back w1=%h w2=%h period=%0d", obs1, obs2, hs2 - hs1);
  endtask

  task automatic test_random();
    logic [63:0] obs; int nb; bit gap; int rb; bit to; int hs;
    logic [WIDTH-1:0] w;
    for (int i = 0; i < 20; i++) begin
      w = WIDTH'($urandom);
      run_word(w, 2, 1'b0, '0, obs, nb, gap, rb, to, hs);
      checks++; if (obs !== expect_bits(w) || nb != NEXP) begin errors++; $display("FAIL random_%0d got %h/%0d want %h/%0d", i, obs, nb, expect_bits(w), NEXP); end
      checks++; if (to || !gap || rb != 0) begin errors++; $display("FAIL random_ctrl_%0d got to=%b gap=%b rb=%0d want 0/1/0", i, to, gap, rb); end
      $display("random %0d word=%h bits=%h", i, w, obs);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_stall();
    test_midword_load();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
